// File: rtl/score_digit_writer.sv
// rtl/score_digit_writer.sv - binary score to decimal glyph writer (iterative double-dabble).
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits with glyph 4'hF.
module score_digit_writer #(
  parameter int SCORE_W = 16,
  parameter int NDIGITS = 5,
  parameter int AW      = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SCORE_W-1:0] score_i,
  input  logic               update_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               wr_en_o,
  output logic [AW-1:0]      wr_addr_o,
  output logic [3:0]         wr_data_o
);

  localparam int          BCD_W   = 4 * NDIGITS;
  localparam int          CW      = $clog2(SCORE_W + 1);
  localparam logic [31:0] MAX_VAL = 32'(10 ** NDIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_WRITE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               pending_q, pending_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [3:0]         data_q, data_d;
  logic [SCORE_W-1:0] capture;
  logic [AW-1:0]      addr_nxt;

  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NDIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Slot 0 is the most significant digit, so slot s reads BCD nibble NDIGITS-1-s.
  function automatic logic [3:0] glyph(input logic [BCD_W-1:0] b, input logic [AW-1:0] slot);
    logic [3:0] d;
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
`endif
    d = b[4*(NDIGITS-1-int'(slot)) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int i = 0; i < NDIGITS - 1; i++) begin
      if (i <= int'(slot) && b[4*(NDIGITS-1-i) +: 4] != 4'd0) lead = 1'b0;
    end
    if (lead && int'(slot) != NDIGITS - 1) d = 4'hF;
`endif
    return d;
  endfunction

  always_comb begin
    capture = (32'(score_i) > MAX_VAL) ? SCORE_W'(MAX_VAL) : score_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      pending_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    data_d    = data_q;
    addr_nxt  = addr_q + AW'(1);
    case (state_q)
      S_IDLE: begin
        if (update_i) begin
          state_d = S_CONVERT;
          bin_d   = capture;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      S_CONVERT: begin
        if (update_i) pending_d = 1'b1;
        {bcd_d, bin_d} = {dabble_adj(bcd_q), bin_q} << 1;
        cnt_d = cnt_q + CW'(1);
        // The first glyph is staged from the final BCD value so it appears with wr_en.
        if (cnt_q == CW'(SCORE_W - 1)) begin
          state_d = S_WRITE;
          addr_d  = '0;
          data_d  = glyph(bcd_d, '0);
        end
      end
      S_WRITE: begin
        if (update_i) pending_d = 1'b1;
        if (addr_q == AW'(NDIGITS - 1)) begin
          state_d = S_DONE;
        end else begin
          addr_d = addr_nxt;
          data_d = glyph(bcd_q, addr_nxt);
        end
      end
      S_DONE: begin
        if (pending_q || update_i) begin
          state_d   = S_CONVERT;
          pending_d = 1'b0;
          bin_d     = capture;
          bcd_d     = '0;
          cnt_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign wr_en_o   = (state_q == S_WRITE);
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;

endmodule

// File: tb/tb_score_digit_writer.sv
// tb/tb_score_digit_writer.sv - randomized self-checking bench with a pass-level reference model.
module tb_score_digit_writer;

  localparam int SW  = 16;
  localparam int ND  = 5;
  localparam int TOT = SW + ND + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        update = 1'b0;
  logic [15:0] score = '0;

  logic       busy_a, done_a, wr_en_a;
  logic [2:0] wr_addr_a;
  logic [3:0] wr_data_a;
  logic       busy_b, done_b, wr_en_b;
  logic [1:0] wr_addr_b;
  logic [3:0] wr_data_b;

  score_digit_writer #(.SCORE_W(16), .NDIGITS(5), .AW(3)) dut_a (
    .clk_i(clk), .rst_i(rst), .score_i(score), .update_i(update),
    .busy_o(busy_a), .done_o(done_a), .wr_en_o(wr_en_a),
    .wr_addr_o(wr_addr_a), .wr_data_o(wr_data_a)
  );

  score_digit_writer #(.SCORE_W(16), .NDIGITS(4), .AW(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .score_i(score), .update_i(update),
    .busy_o(busy_b), .done_o(done_b), .wr_en_o(wr_en_b),
    .wr_addr_o(wr_addr_b), .wr_data_o(wr_data_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
  endtask

  function automatic int sat(input int v, input int nd);
    int mx;
    mx = 10 ** nd - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int glyph(input int v, input int slot, input int nd);
    int p;
    p = 10 ** (nd - 1 - slot);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot != nd - 1 && v < p) return 15;
`endif
    return (v / p) % 10;
  endfunction

  // Reference model: a pass is "active" for TOT cycles, m_t counting 1..TOT.
  int cyc = 0;
  int m_t = 0;
  int m_val = 0;
  bit m_active = 1'b0;
  bit m_pend = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 1'b0;
        m_t      = 0;
        m_pend   = 1'b0;
      end else begin
        cyc++;
        if (!m_active) begin
          if (update) begin
            m_active = 1'b1;
            m_t      = 1;
            m_val    = sat(int'(score), ND);
          end
        end else if (m_t == TOT) begin
          if (m_pend || update) begin
            m_t    = 1;
            m_val  = sat(int'(score), ND);
            m_pend = 1'b0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_t++;
          if (update) m_pend = 1'b1;
        end
      end
    end
  end

  int log_a[$];
  int log_b[$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int wr_rise_edge = 0;
  int done_edge = 0;
  int last_addr = 0;
  int last_data = 0;
  bit prev_wr = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit e_wr;
        bit e_done;
        if (rst) begin
          last_addr = 0;
          last_data = 0;
        end
        e_wr   = m_active && m_t >= SW + 1 && m_t <= SW + ND;
        e_done = m_active && m_t == TOT;
        if (e_wr) begin
          last_addr = m_t - SW - 1;
          last_data = glyph(m_val, last_addr, ND);
        end
        chk("busy", int'(busy_a), int'(m_active));
        chk("done", int'(done_a), int'(e_done));
        chk("wr_en", int'(wr_en_a), int'(e_wr));
        chk("wr_addr", int'(wr_addr_a), last_addr);
        chk("wr_data", int'(wr_data_a), last_data);
      end
      if (wr_en_a) log_a.push_back(int'(wr_data_a));
      if (wr_en_b) log_b.push_back(int'(wr_data_b));
      if (wr_en_a && !prev_wr) wr_rise_edge = cyc + 1;
      if (done_a) begin
        done_cnt_a++;
        done_edge = cyc + 1;
      end
      if (done_b) done_cnt_b++;
      prev_wr = wr_en_a;
    end
  end

  int upd_edge = 0;

  task automatic pulse(input int s);
    @(negedge clk);
    score    = 16'(s);
    update   = 1'b1;
    upd_edge = cyc + 1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy_a && !busy_b) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", int'(ok), 1);
  endtask

  task automatic check_log(input string nm, input int act[$], input int base, input int exp[$]);
    chk({nm, "_count"}, act.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < act.size()) chk(nm, act[base + i], exp[i]);
    end
  endtask

  initial begin
    int ba, bb, da, db;
    int ea[$];
    int eb[$];

    chk("model_glyph_12345_0", glyph(12345, 0, 5), 1);
    chk("model_glyph_12345_4", glyph(12345, 4, 5), 5);
    chk("model_sat_nd4", sat(65535, 4), 9999);
`ifdef LEADING_ZERO_BLANK_EN
    chk("model_glyph_42_2", glyph(42, 2, 5), 15);
`else
    chk("model_glyph_42_2", glyph(42, 2, 5), 0);
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_wr_en", int'(wr_en_a), 0);
    chk("reset_wr_addr", int'(wr_addr_a), 0);
    chk("reset_wr_data", int'(wr_data_a), 0);

    ba = log_a.size(); bb = log_b.size();
    pulse(12345);
    wait_idle();
    ea = '{1, 2, 3, 4, 5};
    eb = '{9, 9, 9, 9};
    check_log("log_12345", log_a, ba, ea);
    check_log("log_12345_nd4", log_b, bb, eb);
    chk("latency_first_wr", wr_rise_edge - upd_edge, 17);
    chk("latency_done", done_edge - upd_edge, 22);

    ba = log_a.size(); bb = log_b.size();
    pulse(0);
    wait_idle();
`ifdef LEADING_ZERO_BLANK_EN
    ea = '{15, 15, 15, 15, 0};
    eb = '{15, 15, 15, 0};
`else
    ea = '{0, 0, 0, 0, 0};
    eb = '{0, 0, 0, 0};
`endif
    check_log("log_zero", log_a, ba, ea);
    check_log("log_zero_nd4", log_b, bb, eb);

    ba = log_a.size(); bb = log_b.size();
    pulse(65535);
    wait_idle();
    ea = '{6, 5, 5, 3, 5};
    eb = '{9, 9, 9, 9};
    check_log("log_65535", log_a, ba, ea);
    check_log("log_65535_nd4", log_b, bb, eb);

    ba = log_a.size(); bb = log_b.size(); da = done_cnt_a; db = done_cnt_b;
    pulse(42);
    repeat (3) @(negedge clk);
    pulse(907);
    wait_idle();
`ifdef LEADING_ZERO_BLANK_EN
    ea = '{15, 15, 15, 4, 2, 15, 15, 9, 0, 7};
    eb = '{15, 15, 4, 2, 15, 9, 0, 7};
`else
    ea = '{0, 0, 0, 4, 2, 0, 0, 9, 0, 7};
    eb = '{0, 0, 4, 2, 0, 9, 0, 7};
`endif
    check_log("log_42_907", log_a, ba, ea);
    check_log("log_42_907_nd4", log_b, bb, eb);
    chk("done_pulses_42_907", done_cnt_a - da, 2);
    chk("done_pulses_42_907_nd4", done_cnt_b - db, 2);

    ba = log_a.size(); da = done_cnt_a;
    pulse(100);
    pulse(200);
    repeat (4) @(negedge clk);
    pulse(300);
    repeat (10) @(negedge clk);
    pulse(400);
    wait_idle();
    chk("collapse_done_pulses", done_cnt_a - da, 2);
    chk("collapse_writes", log_a.size() - ba, 10);

    begin
      bit got;
      got = 1'b0;
      pulse(54321);
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (wr_en_a) begin
          got = 1'b1;
          break;
        end
      end
      chk("reset_reach_write", int'(got), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midreset_busy", int'(busy_a), 0);
      chk("midreset_wr_en", int'(wr_en_a), 0);
      chk("midreset_wr_addr", int'(wr_addr_a), 0);
      chk("midreset_wr_data", int'(wr_data_a), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ba = log_a.size();
      repeat (30) @(negedge clk);
      chk("no_write_after_reset", log_a.size() - ba, 0);
    end

    for (int it = 0; it < 40; it++) begin
      int s;
      s = ($urandom_range(0, 1) == 1) ? int'($urandom % 65536) : int'($urandom % 1000);
      pulse(s);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        repeat ($urandom_range(0, 12)) @(negedge clk);
        pulse(int'($urandom % 65536));
      end
      if ($urandom_range(0, 2) == 0) wait_idle();
      else repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
